st_seq: RTL and testbench
=========================

// Module: st_seq
// PURPOSE
//  Sequencer that drives the mode FSM (st). Debounces the mode key into a 1-cycle
//  state_change pulse. On entry to `RST it sweeps-clears the frame memory through a
//  dedicated write port, then raises rst_ok so the mode FSM advances to `SLEEP.
//  Sits between board inputs / frame-RAM write mux and the st block.
// PARAMETERS
//  DEB_CYCLES  500000  cycles key must be stable before debounced level flips (>=2)
//  ADDR_W      12      frame-memory address width; DEPTH = 2**ADDR_W
//  DATA_W      3       frame-memory pixel width
//  CLR_VAL     0       pixel value written during clear (DATA_W bits)
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous reset, active low
//  key_raw      in   1       raw mode key (BTN1), active high, bouncing, async
//  state        in   3       current mode from st, `RST/`SLEEP/.../`STOP encoding
//  state_change out  1       1-cycle pulse: advance mode
//  rst_ok       out  1       clear finished; held high while state==`RST after sweep
//  clr_we       out  1       frame-memory write enable (clear sweep)
//  clr_addr     out  ADDR_W  frame-memory write address
//  clr_data     out  DATA_W  write data, constant CLR_VAL
//  busy         out  1       clear sweep in progress
// BEHAVIOUR
//  Reset (rst_n=0, async): state_change=0, rst_ok=0, clr_we=0, clr_addr=0, busy=0,
//   debounce sync/level/counter=0, seq FSM=IDLE. clr_data is always CLR_VAL.
//  Debounce: 2-FF synchroniser -> key_s. Counter increments each cycle key_s!=key_deb,
//   clears when equal. When counter==DEB_CYCLES-1 and still differing, key_deb toggles
//   and counter clears. Glitch shorter than DEB_CYCLES is ignored.
//  Pulse: state_change registered = key_deb rising edge AND state not in {`RST,`STOP}
//   AND busy==0. Latency: key_raw stable high sampled at edge 0 -> state_change high
//   for exactly one cycle at edge DEB_CYCLES+3. Gated presses are dropped, never
//   queued. Release edge never pulses. Holding key = one pulse only.
//  Seq FSM (IDLE, CLEAR, DONE):
//   IDLE : state==`RST -> CLEAR, clr_addr=0.
//   CLEAR: clr_we=1, busy=1; clr_addr+1 each cycle; write at DEPTH-1 is last ->
//          DONE (exactly DEPTH write cycles, addr 0..DEPTH-1 in order, no wrap).
//          state!=`RST mid-sweep -> abort to IDLE next edge, clr_we=0, clr_addr=0.
//   DONE : rst_ok=1, clr_we=0, busy=0; state!=`RST -> IDLE, rst_ok=0 next edge.
//  rst_ok rises one edge after the last write; registered, glitch-free (st uses its edge).
//  Re-entry to `RST always restarts sweep from address 0.
//  `STOP: FSM stays IDLE, no pulses, no writes.
//  key edge and sweep start same cycle: sweep wins, pulse suppressed.
// CONFIGURATION
//  SEQ_FAST_RST_EN defined: CLEAR state skipped; IDLE->DONE on `RST, rst_ok one edge
//   after state==`RST seen, clr_we never asserts, busy stays 0 (sim/bring-up).
//  Undefined (default): full clear sweep as above.
// TESTING  (DEB_CYCLES=4, ADDR_W=3, CLR_VAL=0)
//  1 state=`SLEEP, key_raw 0->1 held 20 cyc -> one state_change pulse at edge 7, none after.
//  2 state=`LIGHT, key_raw high 3 cyc then low, repeat x5 -> state_change never asserts.
//  3 state 0->`RST -> clr_we high 8 cyc, clr_addr 0..7, busy=1; rst_ok=1 next edge, held.
//  4 state=`RST during sweep at addr 3 -> state to `SLEEP: clr_we=0, addr=0 next edge, rst_ok=0.
//  5 state=`STOP or sweep busy, clean key press -> no state_change; no late pulse afterwards.
//  6 rst_n pulsed low mid-sweep (addr 5) -> all outputs 0 immediately; with state=`RST sweep restarts at addr 0.

Source files
------------

// File: rtl/st_seq.sv
// Mode-key debouncer and frame-memory clear sequencer that sits in front of the st mode FSM.
// Define SEQ_FAST_RST_EN to skip the clear sweep, so rst_ok follows `RST directly.
module st_seq #(
  parameter int              DEB_CYCLES = 500000,
  parameter int              ADDR_W     = 12,
  parameter int              DATA_W     = 3,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0,
  parameter logic [2:0]      ST_RST     = 3'd1,
  parameter logic [2:0]      ST_STOP    = 3'd7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_raw,
  input  logic [2:0]        state,
  output logic              state_change,
  output logic              rst_ok,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic [DATA_W-1:0] clr_data,
  output logic              busy
);

  localparam int                CNT_W     = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_CLEAR = 2'd1,
    SEQ_DONE  = 2'd2
  } seq_t;

  logic             key_meta_reg, key_s_reg;
  logic             key_deb_reg, key_deb_prev_reg, key_rise_reg;
  logic [CNT_W-1:0] deb_cnt_reg;
  logic             pulse_reg, rst_ok_reg;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  seq_t             seq_reg, seq_next;
  logic             pulse_allowed;

  // Synchroniser plus stability counter: the debounced level only flips after
  // key_s has disagreed with it for DEB_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_reg     <= 1'b0;
      key_s_reg        <= 1'b0;
      key_deb_reg      <= 1'b0;
      key_deb_prev_reg <= 1'b0;
      key_rise_reg     <= 1'b0;
      deb_cnt_reg      <= '0;
    end else begin
      key_meta_reg     <= key_raw;
      key_s_reg        <= key_meta_reg;
      key_deb_prev_reg <= key_deb_reg;
      key_rise_reg     <= key_deb_reg & ~key_deb_prev_reg;
      if (key_s_reg == key_deb_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == CNT_LAST) begin
        key_deb_reg <= ~key_deb_reg;
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      end
    end
  end

  // A press arriving while gated is simply lost; the level is already high so it never re-fires.
  assign pulse_allowed = (state != ST_RST) && (state != ST_STOP) && !busy;

  always_comb begin
    seq_next  = seq_reg;
    addr_next = addr_reg;
    case (seq_reg)
      SEQ_IDLE: begin
        if (state == ST_RST) begin
`ifdef SEQ_FAST_RST_EN
          seq_next = SEQ_DONE;
`else
          seq_next = SEQ_CLEAR;
`endif
          addr_next = '0;
        end
      end
      SEQ_CLEAR: begin
        if (state != ST_RST) begin
          seq_next  = SEQ_IDLE;
          addr_next = '0;
        end else if (addr_reg == ADDR_LAST) begin
          seq_next  = SEQ_DONE;
          addr_next = '0;
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end
      SEQ_DONE: begin
        if (state != ST_RST) seq_next = SEQ_IDLE;
      end
      default: begin
        seq_next  = SEQ_IDLE;
        addr_next = '0;
      end
    endcase
  end

  // rst_ok comes straight from a flop so st sees a clean edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_reg    <= SEQ_IDLE;
      addr_reg   <= '0;
      rst_ok_reg <= 1'b0;
      pulse_reg  <= 1'b0;
    end else begin
      seq_reg    <= seq_next;
      addr_reg   <= addr_next;
      rst_ok_reg <= (seq_next == SEQ_DONE);
      pulse_reg  <= key_rise_reg & pulse_allowed;
    end
  end

  assign state_change = pulse_reg;
  assign rst_ok       = rst_ok_reg;
  assign clr_we       = (seq_reg == SEQ_CLEAR);
  assign busy         = (seq_reg == SEQ_CLEAR);
  assign clr_addr     = addr_reg;
  assign clr_data     = CLR_VAL;

endmodule

// File: tb/tb_st_seq.sv
// Directed bench for st_seq with a short debounce and an 8-entry frame memory.
module tb_st_seq;
  localparam int         DEB = 4;
  localparam int         AW  = 3;
  localparam int         DW  = 3;
  localparam logic [2:0] S_RST   = 3'd1;
  localparam logic [2:0] S_SLEEP = 3'd2;
  localparam logic [2:0] S_LIGHT = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_raw = 1'b0;
  logic [2:0]    state = 3'd0;
  logic          state_change, rst_ok, clr_we, busy;
  logic [AW-1:0] clr_addr;
  logic [DW-1:0] clr_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  st_seq #(
    .DEB_CYCLES(DEB), .ADDR_W(AW), .DATA_W(DW), .CLR_VAL(3'd0),
    .ST_RST(S_RST), .ST_STOP(S_STOP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .state(state),
    .state_change(state_change), .rst_ok(rst_ok), .clr_we(clr_we),
    .clr_addr(clr_addr), .clr_data(clr_data), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_no_pulse(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (state_change !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle %0d: state_change=%b required 0", name, i, state_change);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({state_change, rst_ok, clr_we, busy, clr_addr, clr_data} !== 10'd0) begin
      errors++;
      $display("FAIL reset: sc=%b ok=%b we=%b busy=%b addr=%0d data=%0d required all 0",
               state_change, rst_ok, clr_we, busy, clr_addr, clr_data);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    state = S_SLEEP;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_press();
    key_raw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (state_change !== (k == 7)) begin
        errors++;
        $display("FAIL press edge %0d: state_change=%b required %b", k, state_change, k == 7);
      end
    end
    key_raw = 1'b0;
    expect_no_pulse("release", 12);
    $display("test_press done");
  endtask

  task automatic test_glitch();
    state = S_LIGHT;
    for (int r = 0; r < 5; r++) begin
      key_raw = 1'b1;
      expect_no_pulse("glitch_hi", 3);
      key_raw = 1'b0;
      expect_no_pulse("glitch_lo", 3);
    end
    expect_no_pulse("glitch_tail", 8);
    $display("test_glitch done");
  endtask

  task automatic test_sweep();
    state = 3'd0;
    tick();
    state = S_RST;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (clr_we !== 1'b1 || busy !== 1'b1 || clr_addr !== AW'(k) || rst_ok !== 1'b0) begin
        errors++;
        $display("FAIL sweep cycle %0d: we=%b busy=%b addr=%0d ok=%b required 1 1 %0d 0",
                 k, clr_we, busy, clr_addr, rst_ok, k);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (clr_we !== 1'b0 || busy !== 1'b0 || rst_ok !== 1'b1) begin
        errors++;
        $display("FAIL sweep_done %0d: we=%b busy=%b ok=%b required 0 0 1", k, clr_we, busy, rst_ok);
      end
    end
    state = S_SLEEP;
    tick();
    checks++;
    if (rst_ok !== 1'b0) begin
      errors++;
      $display("FAIL sweep_exit: rst_ok=%b required 0", rst_ok);
    end
    $display("test_sweep done");
  endtask

  task automatic test_abort();
    state = S_RST;
    repeat (4) tick();
    checks++;
    if (clr_addr !== 3'd3 || clr_we !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: addr=%0d we=%b required 3 1", clr_addr, clr_we);
    end
    state = S_SLEEP;
    tick();
    checks++;
    if (clr_we !== 1'b0 || clr_addr !== 3'd0 || rst_ok !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: we=%b addr=%0d ok=%b busy=%b required 0 0 0 0", clr_we, clr_addr, rst_ok, busy);
    end
    tick();
    $display("test_abort done");
  endtask

  task automatic test_gated();
    state = S_STOP;
    key_raw = 1'b1;
    expect_no_pulse("stop_press", 15);
    checks++;
    if (clr_we !== 1'b0) begin
      errors++;
      $display("FAIL stop_we: clr_we=%b required 0", clr_we);
    end
    state = S_SLEEP;
    expect_no_pulse("stop_late", 6);
    key_raw = 1'b0;
    expect_no_pulse("stop_release", 10);
    state = S_RST;
    key_raw = 1'b1;
    expect_no_pulse("busy_press", 12);
    state = S_SLEEP;
    expect_no_pulse("busy_late", 6);
    key_raw = 1'b0;
    expect_no_pulse("busy_release", 10);
    $display("test_gated done");
  endtask

  task automatic test_async_reset();
    state = S_RST;
    repeat (6) tick();
    checks++;
    if (clr_addr !== 3'd5) begin
      errors++;
      $display("FAIL areset_pre: addr=%0d required 5", clr_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state_change, rst_ok, clr_we, busy, clr_addr} !== 7'd0) begin
      errors++;
      $display("FAIL areset: sc=%b ok=%b we=%b busy=%b addr=%0d required all 0",
               state_change, rst_ok, clr_we, busy, clr_addr);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (clr_we !== 1'b1 || clr_addr !== AW'(k)) begin
        errors++;
        $display("FAIL restart %0d: we=%b addr=%0d required 1 %0d", k, clr_we, clr_addr, k);
      end
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_sweep();
    test_abort();
    test_gated();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
